// File: rtl/reg_slice_pkg.sv
// Shared types and limits for the reg_slice_pipe register slice library.
// Optional feature macro: REG_SLICE_PIPE_FLUSH_EN (adds a synchronous flush port).
package reg_slice_pkg;

    // Largest supported number of skid stages in one pipe.
    localparam int REG_SLICE_MAX_DEPTH = 8;

    // Control state of a single skid stage; 2'b11 is unused and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } stage_state_e;

endpackage

// File: rtl/reg_slice_stage.sv
// One two-entry skid stage. out_data is always the main register; in_ready is
// taken straight from the state register so no ready path crosses the stage.
// Optional feature macro: REG_SLICE_PIPE_FLUSH_EN (flush forces the stage EMPTY).
module reg_slice_stage
    import reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef REG_SLICE_PIPE_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    stage_state_e          state;
    stage_state_e          state_nxt;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  in_fire;
    logic                  out_fire;
    logic                  ld_main_in;
    logic                  ld_main_skid;
    logic                  ld_skid;

    // State register; control state always resets.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next-state: EMPTY/BUSY/FULL occupancy walk, flush wins over any handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (in_fire) state_nxt = BUSY;
            BUSY: begin
                if (in_fire && !out_fire)      state_nxt = FULL;
                else if (!in_fire && out_fire) state_nxt = EMPTY;
            end
            FULL:    if (out_fire) state_nxt = BUSY;
            default: state_nxt = EMPTY;
        endcase
`ifdef REG_SLICE_PIPE_FLUSH_EN
        if (flush) state_nxt = EMPTY;
`endif
    end

    // Outputs: handshake flags from state alone, plus data-register load enables.
    always_comb begin
        in_ready     = (state != FULL);
        out_valid    = (state == BUSY) || (state == FULL);
        in_fire      = in_valid && in_ready;
        out_fire     = out_valid && out_ready;
        ld_main_in   = in_fire && ((state == EMPTY) || ((state == BUSY) && out_fire));
        ld_skid      = in_fire && (state == BUSY) && !out_fire;
        ld_main_skid = out_fire && (state == FULL);
    end

    // Data registers; only cleared on reset when RESET_DATA is set.
    always_ff @(posedge clk) begin
        if (RESET_DATA && rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)        main_q <= in_data;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/reg_slice_pipe.sv
// DEPTH chained skid stages on a valid/ready bus; DEPTH=0 is a pure wire.
// Optional feature macro: REG_SLICE_PIPE_FLUSH_EN (adds the flush port).
module reg_slice_pipe
    import reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 1,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic                  clk_d,
    input  logic                  rst_d,
`ifdef REG_SLICE_PIPE_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    if (DEPTH < 0 || DEPTH > REG_SLICE_MAX_DEPTH) begin : g_depth_chk
        $error("reg_slice_pipe: DEPTH out of range");
    end

    if (DEPTH == 0) begin : g_bypass
        // Combinational pass-through; clock, reset and flush are not used.
        logic unused_bypass;
`ifdef REG_SLICE_PIPE_FLUSH_EN
        assign unused_bypass = ^{clk_d, rst_d, flush};
`else
        assign unused_bypass = ^{clk_d, rst_d};
`endif
        assign m_valid = s_valid;
        assign s_ready = m_ready;
        assign m_data  = s_data;
    end else begin : g_pipe
        logic                             blk;
        logic [DEPTH:0]                   vld;
        logic [DEPTH:0]                   rdy;
        logic [DEPTH:0][DATA_WIDTH-1:0]   dat;

        // Reset (and flush) hide both boundary handshakes in the cycle they are
        // asserted; the stages themselves are cleared at the following edge.
`ifdef REG_SLICE_PIPE_FLUSH_EN
        assign blk = rst_d | flush;
`else
        assign blk = rst_d;
`endif

        assign vld[0]     = s_valid;
        assign dat[0]     = s_data;
        assign rdy[DEPTH] = m_ready;
        assign s_ready    = rdy[0] & ~blk;
        assign m_valid    = vld[DEPTH] & ~blk;
        assign m_data     = dat[DEPTH];

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            reg_slice_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk       (clk_d),
                .rst       (rst_d),
`ifdef REG_SLICE_PIPE_FLUSH_EN
                .flush     (flush),
`endif
                .in_valid  (vld[i]),
                .in_ready  (rdy[i]),
                .in_data   (dat[i]),
                .out_valid (vld[i+1]),
                .out_ready (rdy[i+1]),
                .out_data  (dat[i+1])
            );
        end
    end

endmodule

// File: tb/tb_reg_slice_pipe.sv
// Scoreboard bench for reg_slice_pipe: a DEPTH=3 instance checked against an
// in-order expected-beat queue, plus a DEPTH=0 instance checked as a wire.
// Optional feature macro: REG_SLICE_PIPE_FLUSH_EN (enables the flush scenario).
module tb_reg_slice_pipe;
    localparam int DW = 32;
    localparam int D  = 3;

    logic clk_d = 1'b0;
    always #5 clk_d = ~clk_d;

    logic          rst_d, flush, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic          z_s_valid, z_s_ready, z_m_valid, z_m_ready;
    logic [DW-1:0] z_s_data, z_m_data;

    reg_slice_pipe #(.DATA_WIDTH(DW), .DEPTH(D), .RESET_DATA(1'b1)) dut (
        .clk_d   (clk_d),
        .rst_d   (rst_d),
`ifdef REG_SLICE_PIPE_FLUSH_EN
        .flush   (flush),
`endif
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    reg_slice_pipe #(.DATA_WIDTH(DW), .DEPTH(0), .RESET_DATA(1'b0)) dut0 (
        .clk_d   (clk_d),
        .rst_d   (rst_d),
`ifdef REG_SLICE_PIPE_FLUSH_EN
        .flush   (flush),
`endif
        .s_valid (z_s_valid),
        .s_ready (z_s_ready),
        .s_data  (z_s_data),
        .m_valid (z_m_valid),
        .m_ready (z_m_ready),
        .m_data  (z_m_data)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_acc  = 0;
    bit chk_lat = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;
    beat_t exp_q[$];

    always @(posedge clk_d) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reference is an ideal FIFO of accepted beats; reset/flush empty it.
    always @(negedge clk_d) begin
        if (rst_d || flush) begin
            exp_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                check("out_beat_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("out_data", m_data, b.data);
                    if (chk_lat) check("latency", cyc - b.cyc, D);
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back('{data: s_data, cyc: cyc});
                n_acc++;
                check("capacity", exp_q.size() <= 2 * D, 1);
            end
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [DW-1:0] d);
        bit acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_d);
            if (s_ready) begin acc = 1'b1; break; end
        end
        check("send_accepted", acc, 1);
        @(posedge clk_d); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk_d);
        check("drained", exp_q.size(), 0);
        @(posedge clk_d); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, acc_cnt, n, target;
        logic [DW-1:0] v;
        logic sr;

        rst_d = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        z_s_valid = 1'b0; z_s_data = '0; z_m_ready = 1'b0;

        // Reset state.
        @(negedge clk_d);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        repeat (2) @(posedge clk_d);
        #1 rst_d = 1'b0;
        @(negedge clk_d);
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_m_valid", m_valid, 0);

        // Streaming 0..99 with downstream always ready: fixed latency, no bubbles.
        @(posedge clk_d); #1;
        m_ready = 1'b1;
        chk_lat = 1'b1;
        start = cyc;
        for (int i = 0; i < 100; i++) send(DW'(i));
        check("stream_cycles", cyc - start, 100);
        wait_empty();
        chk_lat = 1'b0;

        // Backpressure fill: exactly 2*D beats fit, then release drains in order.
        m_ready = 1'b0;
        s_valid = 1'b1;
        v = 32'd1000;
        acc_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            s_data = v;
            @(negedge clk_d);
            if (s_ready) begin acc_cnt++; v++; end
            @(posedge clk_d); #1;
        end
        s_valid = 1'b0;
        check("fill_count", acc_cnt, 2 * D);
        check("fill_m_valid", m_valid, 1);
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_d);
            if (s_ready) break;
            n++;
        end
        check("release_s_ready_delay_le_depth", n <= D, 1);
        wait_empty();

        // Random valid (70%) / ready (50%), with a mid-cycle m_ready toggle probe.
        target = n_acc + 10000;
        for (int c = 0; c < 60000 && n_acc < target; c++) begin
            @(posedge clk_d); #1;
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = $urandom;
            m_ready = $urandom_range(0, 1) == 1;
            #1;
            sr = s_ready;
            m_ready = ~m_ready;
            #1;
            check("s_ready_indep_of_m_ready", s_ready, sr);
            m_ready = ~m_ready;
        end
        check("random_beats_done", n_acc >= target, 1);
        @(posedge clk_d); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_empty();

        // Reset with three beats in flight: they must never emerge.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'hA0 + DW'(i));
        s_valid = 1'b1;
        s_data  = 32'hBAD;
        rst_d   = 1'b1;
        @(negedge clk_d);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_m_valid", m_valid, 0);
        @(posedge clk_d); #1;
        check("midrst_m_data", m_data, 0);
        check("midrst_m_valid2", m_valid, 0);
        rst_d   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk_d);
        check("midrst_release_s_ready", s_ready, 1);
        check("midrst_release_m_valid", m_valid, 0);
        @(posedge clk_d); #1;
        m_ready = 1'b1;
        send(32'h55);
        wait_empty();

`ifdef REG_SLICE_PIPE_FLUSH_EN
        // Flush with the pipe full and a beat presented in the same cycle.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'hF0 + DW'(i));
        s_valid = 1'b1;
        s_data  = 32'hDEAD;
        flush   = 1'b1;
        @(negedge clk_d);
        check("flush_s_ready", s_ready, 0);
        check("flush_m_valid", m_valid, 0);
        @(posedge clk_d); #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk_d);
        check("post_flush_m_valid", m_valid, 0);
        check("post_flush_s_ready", s_ready, 1);
        @(posedge clk_d); #1;
        m_ready = 1'b1;
        send(32'h77);
        wait_empty();
`endif

        // DEPTH=0 behaves as wires in the same cycle.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_d); #1;
            z_s_valid = $urandom_range(0, 1) == 1;
            z_m_ready = $urandom_range(0, 1) == 1;
            z_s_data  = $urandom;
            #1;
            check("d0_m_valid", z_m_valid, z_s_valid);
            check("d0_s_ready", z_s_ready, z_m_ready);
            check("d0_m_data", z_m_data, z_s_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
